ps2_receiver: RTL
=================

PS2_RECEIVER -- requirements
Module: ps2_receiver

Interface
REQ-001 SHALL have parameter FILTER_LEN, default 8: number of consecutive equal synchronized ps2_clk samples required before the filtered clock changes.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 50000: idle clk cycles inside a frame before the frame is aborted (1 ms at 50 MHz).
REQ-003 SHALL have parameter FIFO_DEPTH, default 4: received-byte FIFO depth, power of two, minimum 2.
REQ-004 clk  input  1  single system clock; all logic rising-edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 ps2_clk  input  1  raw PS/2 clock line, asynchronous to clk.
REQ-007 ps2_data  input  1  raw PS/2 data line, asynchronous to clk.
REQ-008 rx_data  output  8  byte at the FIFO head.
REQ-009 rx_valid  output  1  FIFO not empty.
REQ-010 rx_ready  input  1  consumer accepts rx_data when rx_valid && rx_ready.
REQ-011 frame_err  output  1  one-cycle pulse on a bad or aborted frame.
REQ-012 overflow  output  1  sticky; set when a good byte is dropped because the FIFO is full.
REQ-013 fill  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Function
REQ-014 ps2_clk and ps2_data SHALL each pass through a 2-flop synchronizer before any other use.
REQ-015 The filtered clock SHALL change only after FILTER_LEN consecutive equal synchronized samples that differ from its current value; it resets to 1.
REQ-016 A sample event SHALL occur on the cycle the filtered clock goes 1->0; ps2_data is sampled from the synchronized data on that cycle.
REQ-017 FSM states SHALL be IDLE, DATA, PARITY, STOP.
REQ-018 IDLE: a sample event with data 0 (start bit) -> DATA with bit count 0; data 1 -> stay in IDLE, no error.
REQ-019 DATA: each sample event shifts data LSB-first; after the 8th bit -> PARITY.
REQ-020 PARITY: the sample event captures the parity bit -> STOP.
REQ-021 STOP: on the sample event -> IDLE; the frame is good if stop bit = 1 and the 8 data bits plus parity contain an odd number of ones.
REQ-022 A good frame SHALL push the byte on the cycle after the stop-bit sample event.
REQ-023 A bad frame (stop bit 0 or parity error) SHALL pulse frame_err for exactly one cycle, push nothing, and return the FSM to IDLE.
REQ-024 In DATA, PARITY or STOP, if TIMEOUT_CYCLES cycles pass with no sample event, the FSM SHALL go to IDLE, discard the partial byte, and pulse frame_err once.
REQ-025 The timeout counter SHALL clear on every sample event and whenever the FSM is in IDLE.
REQ-026 FIFO: first-word fall-through; rx_data is valid whenever rx_valid = 1; a pop occurs when rx_valid && rx_ready.
REQ-027 Push with FIFO not full: the byte is stored; fill increments unless a pop happens in the same cycle.
REQ-028 Push with FIFO full and no pop: the byte is dropped, overflow is set, and fill stays at FIFO_DEPTH.
REQ-029 Push with FIFO full and a pop in the same cycle: both succeed; fill stays at FIFO_DEPTH; overflow is unchanged.
REQ-030 Pop with FIFO empty SHALL have no effect.
REQ-031 FIFO read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-032 overflow SHALL clear only on rst.

Reset
REQ-033 With rst high at a clk edge: FSM -> IDLE; bit count, shift register, timeout counter, pointers and fill -> 0; filtered clock and synchronizers -> 1; rx_valid = 0; rx_data = 0; frame_err = 0; overflow = 0.
REQ-034 rst asserted mid-frame SHALL discard the partial frame with no frame_err pulse; the next frame is received normally after rst deasserts.

Verification
REQ-035 Good frame 0x1C (start 0, bits LSB-first, parity 0, stop 1) with rx_ready = 0 -> rx_valid = 1, rx_data = 0x1C, fill = 1, frame_err stays 0.
REQ-036 Frame 0x1C with parity 1 -> one frame_err pulse, fill stays 0; a following good 0xF0 frame -> rx_data = 0xF0.
REQ-037 Five good frames 0x01..0x05 with FIFO_DEPTH = 4 and rx_ready = 0 -> overflow = 1, fill = 4; then rx_ready = 1 -> pops 0x01..0x04 in order, then rx_valid = 0.
REQ-038 Start bit plus 3 data bits, then ps2_clk held high -> frame_err pulse exactly TIMEOUT_CYCLES cycles after the last sample event, FSM returns to IDLE; the next good frame 0x5A is received correctly.
REQ-039 ps2_clk glitch low for FILTER_LEN-1 cycles while in IDLE with ps2_data = 0 -> no sample event, FSM stays in IDLE.
REQ-040 rst pulsed after the 4th data bit -> no frame_err pulse, fill = 0; the next good frame 0xAA is received with rx_data = 0xAA.

Source files
------------

// File: rtl/ps2_receiver.sv
// PS/2 device-to-host receiver: synchronizes and de-glitches the PS/2 lines,
// decodes 11-bit frames (start, 8 data LSB-first, odd parity, stop) and
// queues good bytes in a first-word fall-through FIFO.
module ps2_receiver #(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 50000,
  parameter int unsigned FIFO_DEPTH     = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ps2_clk,
  input  logic                          ps2_data,
  output logic [7:0]                    rx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic                          frame_err,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fill
);

  localparam int unsigned FW = $clog2(FILTER_LEN + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
  // Abort is decided one cycle early so the registered pulse lands exactly
  // TIMEOUT_CYCLES cycles after the last sample event.
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 2);
  localparam logic [AW:0]   FIFO_FULL = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } state_e;

  // Synchronizer and filter
  logic [1:0]    clk_sync_q, clk_sync_d;
  logic [1:0]    data_sync_q, data_sync_d;
  logic          filt_q, filt_d;
  logic [FW-1:0] filt_cnt_q, filt_cnt_d;
  logic          sample_ev;
  logic          sample_bit;

  // Frame decoder
  state_e        state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          parity_q, parity_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          timeout_hit;
  logic          frame_ok;
  logic          push_q, push_d;
  logic [7:0]    push_byte_q, push_byte_d;
  logic          frame_err_q, frame_err_d;

  // FIFO
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   fill_q, fill_d;
  logic          overflow_q, overflow_d;
  logic          full;
  logic          pop;
  logic          wr_en;

  // Two-flop synchronizers and the run-length clock filter
  always_comb begin
    clk_sync_d  = {clk_sync_q[0], ps2_clk};
    data_sync_d = {data_sync_q[0], ps2_data};
    filt_d      = filt_q;
    filt_cnt_d  = '0;
    if (clk_sync_q[1] != filt_q) begin
      if (filt_cnt_q == FILT_LAST) begin
        filt_d = clk_sync_q[1];
      end else begin
        filt_cnt_d = filt_cnt_q + 1'b1;
      end
    end
  end

  assign sample_ev  = filt_q & ~filt_d;
  assign sample_bit = data_sync_q[1];

  // Synchronizer and filter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync_q  <= '1;
      data_sync_q <= '1;
      filt_q      <= 1'b1;
      filt_cnt_q  <= '0;
    end else begin
      clk_sync_q  <= clk_sync_d;
      data_sync_q <= data_sync_d;
      filt_q      <= filt_d;
      filt_cnt_q  <= filt_cnt_d;
    end
  end

  assign timeout_hit = (state_q != IDLE) && !sample_ev && (tmo_q == TMO_LAST);
  assign frame_ok    = sample_bit && (^{shift_q, parity_q});

  // Frame decoder state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      parity_q    <= 1'b0;
      tmo_q       <= '0;
      push_q      <= 1'b0;
      push_byte_q <= '0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      parity_q    <= parity_d;
      tmo_q       <= tmo_d;
      push_q      <= push_d;
      push_byte_q <= push_byte_d;
      frame_err_q <= frame_err_d;
    end
  end

  // Frame decoder next state: advance on sample events, abort on timeout
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    tmo_d     = (state_q == IDLE || sample_ev) ? '0 : tmo_q + 1'b1;
    if (timeout_hit) begin
      state_d = IDLE;
    end else if (sample_ev) begin
      case (state_q)
        IDLE: begin
          if (!sample_bit) begin
            state_d   = DATA;
            bit_cnt_d = '0;
          end
        end
        DATA: begin
          shift_d   = {sample_bit, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == 3'd7) begin
            state_d = PARITY;
          end
        end
        PARITY: begin
          parity_d = sample_bit;
          state_d  = STOP;
        end
        STOP: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Frame decoder outputs: push a good byte or flag a bad/aborted frame
  always_comb begin
    push_d      = 1'b0;
    push_byte_d = push_byte_q;
    frame_err_d = 1'b0;
    if (timeout_hit) begin
      frame_err_d = 1'b1;
    end else if (state_q == STOP && sample_ev) begin
      if (frame_ok) begin
        push_d      = 1'b1;
        push_byte_d = shift_q;
      end else begin
        frame_err_d = 1'b1;
      end
    end
  end

  // FIFO control: a pop frees the slot a same-cycle push into a full FIFO needs
  always_comb begin
    full       = (fill_q == FIFO_FULL);
    pop        = rx_valid && rx_ready;
    wr_en      = push_q && (!full || pop);
    wr_ptr_d   = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    fill_d     = fill_q;
    if (wr_en && !pop) begin
      fill_d = fill_q + 1'b1;
    end else if (!wr_en && pop) begin
      fill_d = fill_q - 1'b1;
    end
    overflow_d = overflow_q | (push_q & full & ~pop);
  end

  // FIFO pointer, occupancy and overflow registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fill_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fill_q     <= fill_d;
      overflow_q <= overflow_d;
    end
  end

  // FIFO storage
  always_ff @(posedge clk) begin
    if (!rst && wr_en) begin
      mem_q[wr_ptr_q] <= push_byte_q;
    end
  end

  assign rx_valid  = (fill_q != '0);
  assign rx_data   = rx_valid ? mem_q[rd_ptr_q] : '0;
  assign frame_err = frame_err_q;
  assign overflow  = overflow_q;
  assign fill      = fill_q;

endmodule
